// File: rtl/am2950_ctl.sv
// ---------------------------------------------------------------------------
// am2950_ctl
//
// Sequencer for an am2950-style bidirectional mailbox port. Mailbox R carries
// data from side A to side B and mailbox S carries data from side B to side A.
// Four transaction types are arbitrated round-robin in the order
// AW -> BR -> BW -> AR: A write (R), B read (R), B write (S), A read (S).
// Only one transaction is in flight at a time. Each one takes three cycles
// after the IDLE cycle that granted it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   a_wr_req, a_rd_req       side A level requests (write R / read S)
//   b_wr_req, b_rd_req       side B level requests (write S / read R)
//   fr, fs                   port R-full / S-full flags
//   cpr, cps                 port capture clocks (one-cycle pulse)
//   cer_, ces_               port capture enables, active low
//   oea_, oeb_               port output enables, active low
//   clrr, clrs               port flag clears (also held high during reset)
//   a_wr_ack .. b_rd_ack     one-cycle completion pulses
//   busy                     high whenever the sequencer is not idle
//   ab_cnt, ba_cnt           completed A->B / B->A transfers (wrapping)
// ---------------------------------------------------------------------------
module am2950_ctl #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_wr_req,
  input  logic            a_rd_req,
  input  logic            b_wr_req,
  input  logic            b_rd_req,
  input  logic            fr,
  input  logic            fs,
  output logic            cpr,
  output logic            cps,
  output logic            cer_,
  output logic            ces_,
  output logic            oea_,
  output logic            oeb_,
  output logic            clrr,
  output logic            clrs,
  output logic            a_wr_ack,
  output logic            a_rd_ack,
  output logic            b_wr_ack,
  output logic            b_rd_ack,
  output logic            busy,
  output logic [CNTW-1:0] ab_cnt,
  output logic [CNTW-1:0] ba_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W1   = 3'd1,
    W2   = 3'd2,
    W3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6
  } state_t;

  // Transaction codes, numbered in round-robin order.
  localparam logic [1:0] T_AW = 2'd0;
  localparam logic [1:0] T_BR = 2'd1;
  localparam logic [1:0] T_BW = 2'd2;
  localparam logic [1:0] T_AR = 2'd3;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t     state_r;
  logic [1:0] cur_r;    // transaction in flight
  logic [1:0] last_r;   // most recent grant, lowest priority next time
  logic       clrr_r;
  logic       clrs_r;
  logic [3:0] elig_s;   // indexed by transaction code
  logic [2:0] pick_s;   // {valid, transaction code}

  // Round-robin pick: scan from last+1 around to last. Later loop iterations
  // overwrite earlier ones, so the scan runs from lowest to highest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (elig[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Eligibility: a write needs the target mailbox empty, a read needs it full.
  always_comb begin
    elig_s       = 4'b0000;
    elig_s[T_AW] = a_wr_req & ~fr;
    elig_s[T_BR] = b_rd_req &  fr;
    elig_s[T_BW] = b_wr_req & ~fs;
    elig_s[T_AR] = a_rd_req &  fs;
    pick_s       = rr_pick(elig_s, last_r);
  end

  // Flag clears are registered, but reset also forces them high so the port
  // flags clear for as long as reset is held.
  assign clrr = clrr_r | rst;
  assign clrs = clrs_r | rst;

  // Sequencer: state, grant tracking, registered port controls and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cur_r    <= T_AW;
      last_r   <= T_AR;   // makes AW the highest priority after reset
      cpr      <= 1'b0;
      cps      <= 1'b0;
      cer_     <= 1'b1;
      ces_     <= 1'b1;
      oea_     <= 1'b1;
      oeb_     <= 1'b1;
      clrr_r   <= 1'b0;
      clrs_r   <= 1'b0;
      a_wr_ack <= 1'b0;
      a_rd_ack <= 1'b0;
      b_wr_ack <= 1'b0;
      b_rd_ack <= 1'b0;
      busy     <= 1'b0;
      ab_cnt   <= {CNTW{1'b0}};
      ba_cnt   <= {CNTW{1'b0}};
    end else begin
      // Pulsed outputs default low every cycle.
      cpr      <= 1'b0;
      cps      <= 1'b0;
      clrr_r   <= 1'b0;
      clrs_r   <= 1'b0;
      a_wr_ack <= 1'b0;
      a_rd_ack <= 1'b0;
      b_wr_ack <= 1'b0;
      b_rd_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_s[2]) begin
            cur_r  <= pick_s[1:0];
            last_r <= pick_s[1:0];
            busy   <= 1'b1;
            case (pick_s[1:0])
              T_AW: begin
                state_r <= W1;
                cer_    <= 1'b0;
              end
              T_BW: begin
                state_r <= W1;
                ces_    <= 1'b0;
              end
              T_BR: begin
                state_r <= R1;
                oeb_    <= 1'b0;
              end
              default: begin    // T_AR
                state_r <= R1;
                oea_    <= 1'b0;
              end
            endcase
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        W1: begin
          state_r <= W2;
          if (cur_r == T_AW) begin
            cpr <= 1'b1;
          end else begin
            cps <= 1'b1;
          end
        end
        W2: begin
          state_r <= W3;
          cer_    <= 1'b1;
          ces_    <= 1'b1;
          if (cur_r == T_AW) begin
            a_wr_ack <= 1'b1;
          end else begin
            b_wr_ack <= 1'b1;
          end
        end
        R1: begin
          state_r <= R2;
          if (cur_r == T_BR) begin
            b_rd_ack <= 1'b1;
          end else begin
            a_rd_ack <= 1'b1;
          end
        end
        R2: begin
          // Transfer is counted as the reader releases the bus and clears the flag.
          state_r <= R3;
          oea_    <= 1'b1;
          oeb_    <= 1'b1;
          if (cur_r == T_BR) begin
            clrr_r <= 1'b1;
            ab_cnt <= ab_cnt + CNT_ONE;
          end else begin
            clrs_r <= 1'b1;
            ba_cnt <= ba_cnt + CNT_ONE;
          end
        end
        W3, R3: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cer_    <= 1'b1;
          ces_    <= 1'b1;
          oea_    <= 1'b1;
          oeb_    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am2950_ctl.sv
// ---------------------------------------------------------------------------
// tb_am2950_ctl
//
// Transaction-level reference model. Each step drives the requests and the
// modelled port flags in IDLE. The model then picks a grant from a rotating
// priority list and expects the per-cycle control pattern of that transaction
// type. Flags and counters are updated from the transaction's effect.
// ---------------------------------------------------------------------------
module tb_am2950_ctl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_wr_req = 1'b0, a_rd_req = 1'b0, b_wr_req = 1'b0, b_rd_req = 1'b0;
  logic          fr = 1'b0, fs = 1'b0;
  logic          cpr, cps, cer_, ces_, oea_, oeb_, clrr, clrs;
  logic          a_wr_ack, a_rd_ack, b_wr_ack, b_rd_ack, busy;
  logic [CW-1:0] ab_cnt, ba_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: priority list (0=AW 1=BR 2=BW 3=AR), flags, transfer totals.
  int   ord [4];
  logic fr_m, fs_m;
  int   ab_m, ba_m;

  am2950_ctl #(.CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .a_wr_req(a_wr_req), .a_rd_req(a_rd_req),
    .b_wr_req(b_wr_req), .b_rd_req(b_rd_req),
    .fr(fr), .fs(fs),
    .cpr(cpr), .cps(cps), .cer_(cer_), .ces_(ces_),
    .oea_(oea_), .oeb_(oeb_), .clrr(clrr), .clrs(clrs),
    .a_wr_ack(a_wr_ack), .a_rd_ack(a_rd_ack),
    .b_wr_ack(b_wr_ack), .b_rd_ack(b_rd_ack),
    .busy(busy), .ab_cnt(ab_cnt), .ba_cnt(ba_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outvec();
    return {cpr, cps, cer_, ces_, oea_, oeb_, clrr, clrs,
            a_wr_ack, a_rd_ack, b_wr_ack, b_rd_ack, busy};
  endfunction

  // Expected controls for transaction kind k in its cycle c (c=0: idle).
  function automatic logic [12:0] exp_vec(input int k, input int c);
    logic cpr_e, cps_e, cer_e, ces_e, oea_e, oeb_e, clrr_e, clrs_e;
    logic awa, ara, bwa, bra, busy_e;
    cpr_e = 1'b0; cps_e = 1'b0; cer_e = 1'b1; ces_e = 1'b1;
    oea_e = 1'b1; oeb_e = 1'b1; clrr_e = 1'b0; clrs_e = 1'b0;
    awa = 1'b0; ara = 1'b0; bwa = 1'b0; bra = 1'b0; busy_e = 1'b0;
    if (c > 0) begin
      busy_e = 1'b1;
      case (k)
        0: begin cer_e = (c == 3); cpr_e = (c == 2); awa = (c == 3); end
        2: begin ces_e = (c == 3); cps_e = (c == 2); bwa = (c == 3); end
        1: begin oeb_e = (c == 3); bra = (c == 2); clrr_e = (c == 3); end
        default: begin oea_e = (c == 3); ara = (c == 2); clrs_e = (c == 3); end
      endcase
    end
    return {cpr_e, cps_e, cer_e, ces_e, oea_e, oeb_e, clrr_e, clrs_e,
            awa, ara, bwa, bra, busy_e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ord[i] = i;
    fr_m = 1'b0; fs_m = 1'b0; ab_m = 0; ba_m = 0;
  endtask

  // One arbitration step, entered and left at a negedge with the DUT idle.
  // req bits: [0]=a_wr [1]=b_rd [2]=b_wr [3]=a_rd
  task automatic run_txn(input logic [3:0] req);
    logic [3:0] el;
    int g, tmp;
    a_wr_req = req[0]; b_rd_req = req[1]; b_wr_req = req[2]; a_rd_req = req[3];
    fr = fr_m; fs = fs_m;
    el = {req[3] & fs_m, req[2] & ~fs_m, req[1] & fr_m, req[0] & ~fr_m};
    g = -1;
    for (int k = 0; k < 4; k++) if (g < 0 && el[ord[k]]) g = ord[k];
    @(posedge clk); @(negedge clk);
    if (g < 0) begin
      check("idle_wait", 32'(outvec()), 32'(exp_vec(0, 0)));
    end else begin
      for (int c = 1; c <= 3; c++) begin
        if (c == 3) begin
          if (g == 1) ab_m++;
          if (g == 3) ba_m++;
          check("ab_cnt", 32'(ab_cnt), 32'(ab_m % 16));
          check("ba_cnt", 32'(ba_cnt), 32'(ba_m % 16));
        end
        check($sformatf("txn k%0d c%0d", g, c), 32'(outvec()), 32'(exp_vec(g, c)));
        if (c < 3) begin @(posedge clk); @(negedge clk); end
      end
      case (g)
        0: begin fr_m = 1'b1; a_wr_req = 1'b0; end
        1: begin fr_m = 1'b0; b_rd_req = 1'b0; end
        2: begin fs_m = 1'b1; b_wr_req = 1'b0; end
        default: begin fs_m = 1'b0; a_rd_req = 1'b0; end
      endcase
      fr = fr_m; fs = fs_m;
      while (ord[3] != g) begin
        tmp = ord[0]; ord[0] = ord[1]; ord[1] = ord[2]; ord[2] = ord[3]; ord[3] = tmp;
      end
      @(posedge clk); @(negedge clk);
      check("back_idle", 32'(outvec()), 32'(exp_vec(0, 0)));
    end
  endtask

  initial begin
    model_reset();
    // Reset state: everything inactive except the combinational flag clears.
    repeat (2) @(negedge clk);
    #1;
    check("reset_vec", 32'(outvec()), 32'(exp_vec(0, 0) | 13'b0000001100000));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_reset", 32'(outvec()), 32'(exp_vec(0, 0)));
    check("cnt_reset", 32'({ab_cnt, ba_cnt}), 32'd0);

    // Basic write then read of mailbox R.
    run_txn(4'b0001);
    run_txn(4'b0010);

    // All four requesting with R empty and S full.
    fr_m = 1'b0; fs_m = 1'b1;
    repeat (4) run_txn(4'b1111);
    repeat (2) run_txn(4'b0000);

    // B read of an empty R waits indefinitely, then AW unblocks it.
    if (fr_m) run_txn(4'b0010);
    repeat (50) run_txn(4'b0010);
    run_txn(4'b0011);
    run_txn(4'b0011);

    // Asynchronous reset in the middle of a write.
    if (fr_m) run_txn(4'b0010);
    a_wr_req = 1'b1; fr = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_w1", 32'(outvec()), 32'(exp_vec(0, 1)));
    @(posedge clk); @(negedge clk);
    check("abort_w2", 32'(outvec()), 32'(exp_vec(0, 2)));
    #1 rst = 1'b1;
    #1 check("abort_vec", 32'(outvec()), 32'(exp_vec(0, 0) | 13'b0000001100000));
    a_wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fr = 1'b0; fs = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_idle", 32'(outvec()), 32'(exp_vec(0, 0)));
    check("abort_cnt", 32'({ab_cnt, ba_cnt}), 32'd0);

    // Counter wrap: 15 round trips reach the maximum, one more wraps to 0.
    repeat (15) begin run_txn(4'b0001); run_txn(4'b0010); end
    check("ab_max", 32'(ab_cnt), 32'd15);
    run_txn(4'b0001); run_txn(4'b0010);
    check("ab_wrap", 32'(ab_cnt), 32'd0);

    // Randomized traffic, with occasional random flag states from the port.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        fr_m = 1'($urandom_range(0, 1));
        fs_m = 1'($urandom_range(0, 1));
      end
      run_txn(4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
